fsk_bitstreamer_m: RTL and testbench
====================================

Name: fsk_bitstreamer_m

Overview:
M-ary successor to the 2-FSK bitstreamer. It serialises a latched data word as symbols of BITS_PER_SYM bits. Each symbol is emitted as one square-wave period whose half-period comes from a runtime table indexed by the symbol value, with a runtime phase offset. Symbols are gap-free and back-to-back. The block adds start/busy/done handshaking, a runtime symbol count and abort. It drives the antenna modulator switch control and symbol-tag output.

Parameters:
DATALEN, 64, width of data word.
BITS_PER_SYM, 1, bits per symbol (1..3); NSYMV = 2**BITS_PER_SYM table entries.
CNTLEN, 8, width of half-period/phase counters.
LENLEN, 7, width of symbol-count input.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
datain  in  DATALEN  payload, symbol 0 = datain[BITS_PER_SYM-1:0].
nsym  in  LENLEN  number of symbols to send.
halfper_tbl  in  NSYMV*CNTLEN  packed half-period H[v] in clk cycles, entry v at [v*CNTLEN +: CNTLEN].
phase_delay  in  CNTLEN  leading high-time D in clk cycles.
start  in  1  request; sampled only in IDLE.
abort  in  1  synchronous cancel.
busy  out  1  high from accept to end of last symbol.
done  out  1  one-cycle pulse after normal completion.
out  out  1  modulator waveform.
symout  out  BITS_PER_SYM  value of symbol currently on out.

Behaviour:
- Reset (rst_n=0, async): state IDLE; out=0, busy=0, done=0, symout=0; all counters/shadow regs cleared.
- States: IDLE, HEAD, LOW, TAIL, FIN.
- IDLE: out=0, busy=0. At a rising edge with start=1: latch datain, nsym, halfper_tbl, phase_delay into shadow regs. Inputs are don't-care afterwards.
- Accept with nsym=0: go to FIN directly, no waveform.
- Accept with nsym>DATALEN/BITS_PER_SYM: clamp to DATALEN/BITS_PER_SYM.
- Accept otherwise: load symbol 0; busy=1 and the first waveform cycle appear in the cycle after the accepting edge.
- Per-symbol load: v = shift_reg[BITS_PER_SYM-1:0]; H = H[v], with 0 treated as 1; Deff = min(D, H); symout = v.
- Per-symbol waveform, exactly 2*H cycles:
  - HEAD: out=1 for Deff cycles; skipped if Deff=0.
  - LOW: out=0 for H cycles.
  - TAIL: out=1 for H-Deff cycles; skipped if 0.
- Symbol end: shift_reg >>= BITS_PER_SYM; decrement remaining count. If remaining>0, load the next symbol so its first cycle immediately follows the previous symbol's last cycle, with zero gap cycles. Else go to FIN.
- FIN (one cycle): out=0, busy=0, done=1, then IDLE. start is not accepted in the FIN cycle.
- Counters are CNTLEN-bit down-counters; no wrap is possible because H ≤ 2^CNTLEN-1.
- start while busy: ignored, no queueing.
- abort=1 in any non-IDLE state: next edge → IDLE, out=0, busy=0, symout=0, no done.
- abort has priority over start and over symbol advance. abort in IDLE: no effect, and start is also blocked that cycle.
- Reset mid-symbol: outputs return to reset values asynchronously; no partial done.

Test Plan:
- BITS_PER_SYM=1, H[0]=2, H[1]=4, D=1, datain=...01, nsym=2, start pulse → out over 12 cycles = 1,0,0,0,0,1,1,1 | 1,0,0,1; symout=1 for 8 cycles then 0 for 4; done pulses in cycle 13; busy high cycles 1–12.
- BITS_PER_SYM=2, H={2,3,4,5}, D=0, datain=...1110_0100 (symbols 0,1,2,3), nsym=4 → low/high runs 2/2, 3/3, 4/4, 5/5 (28 cycles), out starts low, symout 0→1→2→3, done once.
- D=7 with H=3 → Deff clamps to 3: out 1,1,1,0,0,0; no tail; next symbol starts immediately.
- nsym=0 → no out activity; busy stays 0; done pulse one cycle after the accept cycle. nsym=100 with DATALEN=64, BITS_PER_SYM=1 → exactly 64 symbols sent.
- abort asserted mid-LOW of symbol 3 → next cycle out=0, busy=0, no done. A start two cycles later is accepted normally.
- rst_n pulled low mid-TAIL → out/busy/done/symout=0 immediately. start held high during busy changes nothing, and the new data is not latched.

Source files
------------

// File: rtl/fsk_bitstreamer_m.sv
// M-ary FSK bitstreamer: serialises a latched word as BITS_PER_SYM-bit symbols, one square-wave
// period per symbol, with the half-period taken from a runtime table and a leading phase offset.
//
// state | meaning
// IDLE  | waiting for start, out low
// HEAD  | leading high time of the current symbol (Deff cycles)
// LOW   | low half of the current symbol (H cycles)
// TAIL  | trailing high time of the current symbol (H-Deff cycles)
// FIN   | one-cycle done pulse after the last symbol
module fsk_bitstreamer_m #(
  parameter int DATALEN      = 64,
  parameter int BITS_PER_SYM = 1,
  parameter int CNTLEN       = 8,
  parameter int LENLEN       = 7
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATALEN-1:0]                       datain,
  input  logic [LENLEN-1:0]                        nsym,
  input  logic [(2**BITS_PER_SYM)*CNTLEN-1:0]      halfper_tbl,
  input  logic [CNTLEN-1:0]                        phase_delay,
  input  logic                                     start,
  input  logic                                     abort,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     out,
  output logic [BITS_PER_SYM-1:0]                  symout
);

  localparam int NSYMV  = 2**BITS_PER_SYM;
  localparam int TBLW   = NSYMV*CNTLEN;
  localparam int MAXSYM = DATALEN/BITS_PER_SYM;

  typedef enum logic [2:0] {IDLE, HEAD, LOW, TAIL, FIN} state_t;

  state_t                  state_q, state_d;
  logic [CNTLEN-1:0]       cnt_q, cnt_d;
  logic [CNTLEN-1:0]       h_q, h_d;
  logic [CNTLEN-1:0]       deff_q, deff_d;
  logic [CNTLEN-1:0]       dly_q, dly_d;
  logic [TBLW-1:0]         tbl_q, tbl_d;
  logic [DATALEN-1:0]      shift_q, shift_d;
  logic [LENLEN-1:0]       rem_q, rem_d;
  logic [BITS_PER_SYM-1:0] sym_q, sym_d;

  logic                    ld;
  logic [DATALEN-1:0]      ld_src;
  logic [TBLW-1:0]         ld_tbl;
  logic [CNTLEN-1:0]       ld_dly;
  logic [BITS_PER_SYM-1:0] ld_v;
  logic [CNTLEN-1:0]       ld_hraw, ld_h, ld_deff;
  logic [CNTLEN-1:0]       tail_len;
  logic [LENLEN-1:0]       nsym_clamp;

  // On accept the shadow regs are not yet loaded, so the first symbol is decoded from the inputs.
  assign ld_src   = (state_q == IDLE) ? datain      : (shift_q >> BITS_PER_SYM);
  assign ld_tbl   = (state_q == IDLE) ? halfper_tbl : tbl_q;
  assign ld_dly   = (state_q == IDLE) ? phase_delay : dly_q;
  assign ld_v     = ld_src[BITS_PER_SYM-1:0];
  assign ld_hraw  = ld_tbl[ld_v*CNTLEN +: CNTLEN];
  assign ld_h     = (ld_hraw == '0) ? CNTLEN'(1) : ld_hraw;
  assign ld_deff  = (ld_dly > ld_h) ? ld_h : ld_dly;
  assign tail_len = h_q - deff_q;
  assign nsym_clamp = (int'(nsym) > MAXSYM) ? LENLEN'(MAXSYM) : nsym;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      deff_q  <= '0;
      dly_q   <= '0;
      tbl_q   <= '0;
      shift_q <= '0;
      rem_q   <= '0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      deff_q  <= deff_d;
      dly_q   <= dly_d;
      tbl_q   <= tbl_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      sym_q   <= sym_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    deff_d  = deff_q;
    dly_d   = dly_q;
    tbl_d   = tbl_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    sym_d   = sym_q;
    ld      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          tbl_d   = halfper_tbl;
          dly_d   = phase_delay;
          shift_d = datain;
          rem_d   = nsym_clamp;
          if (nsym_clamp == '0) state_d = FIN;
          else                  ld = 1'b1;
        end
      end
      HEAD: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = h_q - CNTLEN'(1);
        end else begin
          cnt_d = cnt_q - CNTLEN'(1);
        end
      end
      LOW, TAIL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTLEN'(1);
        end else if (state_q == LOW && tail_len != '0) begin
          state_d = TAIL;
          cnt_d   = tail_len - CNTLEN'(1);
        end else begin
          // symbol end: next symbol starts on the very next cycle
          rem_d = rem_q - LENLEN'(1);
          if (rem_q > LENLEN'(1)) begin
            shift_d = shift_q >> BITS_PER_SYM;
            ld      = 1'b1;
          end else begin
            state_d = FIN;
            sym_d   = '0;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ld) begin
      h_d    = ld_h;
      deff_d = ld_deff;
      sym_d  = ld_v;
      if (ld_deff != '0) begin
        state_d = HEAD;
        cnt_d   = ld_deff - CNTLEN'(1);
      end else begin
        state_d = LOW;
        cnt_d   = ld_h - CNTLEN'(1);
      end
    end

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      sym_d   = '0;
    end
  end

  assign out    = (state_q == HEAD) || (state_q == TAIL);
  assign busy   = (state_q == HEAD) || (state_q == LOW) || (state_q == TAIL);
  assign done   = (state_q == FIN);
  assign symout = sym_q;

endmodule

// File: tb/tb_fsk_bitstreamer_m.sv
// Bench for fsk_bitstreamer_m: a 1-bit-symbol and a 2-bit-symbol instance, each checked per cycle
// against a queue of expected out/busy/done/symout values built from a waveform model.
module tb_fsk_bitstreamer_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] datain = '0;
  logic [6:0]  nsym = '0;
  logic [7:0]  dly = '0;
  logic        abort = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [15:0] tbl1 = '0;
  logic [31:0] tbl2 = '0;
  logic        busy1, done1, out1, busy2, done2, out2;
  logic [0:0]  sym1;
  logic [1:0]  sym2;

  always #5 clk = ~clk;

  fsk_bitstreamer_m #(.DATALEN(64), .BITS_PER_SYM(1), .CNTLEN(8), .LENLEN(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .datain(datain), .nsym(nsym), .halfper_tbl(tbl1),
    .phase_delay(dly), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .out(out1), .symout(sym1));

  fsk_bitstreamer_m #(.DATALEN(64), .BITS_PER_SYM(2), .CNTLEN(8), .LENLEN(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .datain(datain), .nsym(nsym), .halfper_tbl(tbl2),
    .phase_delay(dly), .start(start2), .abort(abort), .busy(busy2), .done(done2),
    .out(out2), .symout(sym2));

  typedef struct packed {
    logic       o;
    logic       b;
    logic       d;
    logic [2:0] s;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  function automatic int hsym(input logic [63:0] tbl, input int v);
    int h;
    h = int'(tbl[v*8 +: 8]);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int symv(input int bps, input logic [63:0] data, input int i);
    logic [63:0] m;
    m = (data >> (i*bps)) & 64'((1 << bps) - 1);
    return int'(m);
  endfunction

  task automatic push_frame(input int bps, input logic [63:0] data, input int n,
                            input logic [63:0] tbl, input int d);
    int maxs, v, h, de;
    maxs = 64 / bps;
    if (n > maxs) n = maxs;
    for (int i = 0; i < n; i++) begin
      v  = symv(bps, data, i);
      h  = hsym(tbl, v);
      de = (d > h) ? h : d;
      for (int j = 0; j < de; j++)     q.push_back('{1'b1, 1'b1, 1'b0, 3'(v)});
      for (int j = 0; j < h; j++)      q.push_back('{1'b0, 1'b1, 1'b0, 3'(v)});
      for (int j = 0; j < h - de; j++) q.push_back('{1'b1, 1'b1, 1'b0, 3'(v)});
    end
    q.push_back('{1'b0, 1'b0, 1'b1, 3'd0});
    q.push_back('{1'b0, 1'b0, 1'b0, 3'd0});
  endtask

  task automatic check_q(input int sel, input string name, input int maxn);
    exp_t e, a;
    int k;
    k = 0;
    while (q.size() > 0 && k < maxn) begin
      @(negedge clk);
      e = q.pop_front();
      if (sel == 1) a = '{out1, busy1, done1, {2'b00, sym1}};
      else          a = '{out2, busy2, done2, {1'b0, sym2}};
      total++;
      if ({a.o, a.b, a.d} !== {e.o, e.b, e.d} || (e.b && a.s !== e.s)) begin
        bad++;
        $display("FAIL %s cyc=%0d got o/b/d/s=%b%b%b/%0d want %b%b%b/%0d",
                 name, k + 1, a.o, a.b, a.d, a.s, e.o, e.b, e.d, e.s);
      end
      k++;
    end
  endtask

  task automatic start_frame(input int sel);
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({out1, busy1, done1, sym1, out2, busy2, done2, sym2} !== 9'b0) begin
      bad++;
      $display("FAIL reset got %b want 0", {out1, busy1, done1, sym1, out2, busy2, done2, sym2});
    end
    rst_n = 1'b1;
    q.push_back('{1'b0, 1'b0, 1'b0, 3'd0});
    check_q(1, "reset_idle", 2);
  endtask

  task automatic test_basic_b1();
    datain = 64'h1; nsym = 7'd2; dly = 8'd1; tbl1 = 16'h0402;
    push_frame(1, datain, 2, 64'(tbl1), 1);
    start_frame(1);
    check_q(1, "basic_b1", 1000);
  endtask

  task automatic test_mary_b2();
    datain = 64'hE4; nsym = 7'd4; dly = 8'd0; tbl2 = 32'h05040302;
    push_frame(2, datain, 4, 64'(tbl2), 0);
    start_frame(2);
    check_q(2, "mary_b2", 1000);
  endtask

  task automatic test_clamp_phase();
    // D=7 exceeds every H; entry 2 is zero and must behave as H=1
    datain = 64'hE4; nsym = 7'd4; dly = 8'd7; tbl2 = 32'h04000203;
    push_frame(2, datain, 4, 64'(tbl2), 7);
    start_frame(2);
    check_q(2, "clamp_phase", 1000);
  endtask

  task automatic test_nsym_zero();
    datain = 64'hFFFF; nsym = 7'd0; dly = 8'd1; tbl1 = 16'h0302;
    push_frame(1, datain, 0, 64'(tbl1), 1);
    start_frame(1);
    check_q(1, "nsym_zero", 1000);
  endtask

  task automatic test_clamp_len();
    datain = {$urandom, $urandom}; nsym = 7'd100; dly = 8'd0; tbl1 = 16'h0201;
    push_frame(1, datain, 100, 64'(tbl1), 0);
    start_frame(1);
    check_q(1, "clamp_len", 1000);
  endtask

  task automatic test_abort();
    int k, h;
    datain = {$urandom, $urandom}; nsym = 7'd6; dly = 8'd1; tbl1 = 16'h0403;
    push_frame(1, datain, 6, 64'(tbl1), 1);
    k = 0;
    for (int i = 0; i < 3; i++) k += 2 * hsym(64'(tbl1), symv(1, datain, i));
    h = hsym(64'(tbl1), symv(1, datain, 3));
    k += ((h < 1) ? h : 1) + 2;
    while (q.size() > k) void'(q.pop_back());
    start_frame(1);
    check_q(1, "abort_pre", k);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    repeat (3) q.push_back('{1'b0, 1'b0, 1'b0, 3'd0});
    check_q(1, "abort_post", 1000);
    datain = 64'h2; nsym = 7'd3; dly = 8'd2; tbl1 = 16'h0305;
    push_frame(1, datain, 3, 64'(tbl1), 2);
    start_frame(1);
    check_q(1, "abort_restart", 1000);
    // abort while idle must block a simultaneous start
    @(negedge clk);
    abort = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; start1 = 1'b0;
    repeat (2) q.push_back('{1'b0, 1'b0, 1'b0, 3'd0});
    check_q(1, "abort_idle", 1000);
  endtask

  task automatic test_hold_start();
    datain = 64'h5; nsym = 7'd3; dly = 8'd1; tbl1 = 16'h0302;
    push_frame(1, datain, 3, 64'(tbl1), 1);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    datain = 64'hA; nsym = 7'd9; dly = 8'd0; tbl1 = 16'h0607;
    check_q(1, "hold_busy", 4);
    start1 = 1'b0;
    check_q(1, "hold_rest", 1000);
  endtask

  task automatic test_reset_mid_tail();
    datain = 64'h0; nsym = 7'd2; dly = 8'd1; tbl1 = 16'h0404;
    push_frame(1, datain, 2, 64'(tbl1), 1);
    start_frame(1);
    check_q(1, "pre_rst", 6);
    q.delete();
    rst_n = 1'b0;
    #1;
    total++;
    if ({out1, busy1, done1, sym1} !== 4'b0) begin
      bad++;
      $display("FAIL rst_mid_tail got %b want 0000", {out1, busy1, done1, sym1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) q.push_back('{1'b0, 1'b0, 1'b0, 3'd0});
    check_q(1, "post_rst", 1000);
  endtask

  initial begin
    test_reset();
    test_basic_b1();
    test_mary_b2();
    test_clamp_phase();
    test_nsym_zero();
    test_clamp_len();
    test_abort();
    test_hold_start();
    test_reset_mid_tail();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
